// File: rtl/addsub_acc_pipe_if.sv
// Operand/result bus for addsub_acc_pipe: issue handshake, accumulator clear and result/flags.
// master = operand source and result consumer, slave = the pipeline.
interface addsub_acc_pipe_if #(
  parameter int unsigned dw = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [dw-1:0] dataa;
  logic [dw-1:0] datab;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [dw-1:0] result;
  logic          carry;
  logic          ovf;
  logic          zero;
  logic [dw-1:0] acc;

  modport master (
    output in_valid, op, dataa, datab, acc_clr, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, acc
  );

  modport slave (
    input  in_valid, op, dataa, datab, acc_clr, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, acc
  );
endinterface

// File: rtl/addsub_acc_pipe.sv
// Two-stage add/sub pipeline with running accumulator, flags and valid/ready backpressure.
// Define ADDSUB_SAT_EN to clamp overflowing results (and accumulator) to signed max/min.
module addsub_acc_pipe #(
  parameter int unsigned dw = 8
) (
  input  logic             clk,
  input  logic             reset,
  addsub_acc_pipe_if.slave bus
);

  logic          s1_valid_q;
  logic [1:0]    s1_op_q;
  logic [dw-1:0] s1_a_q, s1_b_q;

  logic          out_valid_q;
  logic [dw-1:0] result_q;
  logic          carry_q, ovf_q, zero_q;
  logic [dw-1:0] acc_q;

  logic          en1, en2, mv2;
  logic          is_sub, ovf_c;
  logic [dw-1:0] acc_in, x, y, r_wrap, r_fin;
  logic [dw:0]   full;

  assign en2 = !out_valid_q || bus.out_ready;
  assign en1 = !s1_valid_q || en2;
  assign mv2 = s1_valid_q && en2;

  always_comb begin
    // Clear-then-op: an acc op entering S2 alongside acc_clr sees a zero accumulator.
    acc_in = bus.acc_clr ? '0 : acc_q;
    is_sub = (s1_op_q[1] == s1_op_q[0]);
    x      = s1_op_q[1] ? acc_in : s1_a_q;
    y      = s1_op_q[1] ? s1_a_q : s1_b_q;
    full   = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    r_wrap = full[dw-1:0];
    ovf_c  = (is_sub ? (x[dw-1] != y[dw-1]) : (x[dw-1] == y[dw-1])) &&
             (r_wrap[dw-1] != x[dw-1]);
    r_fin  = r_wrap;
`ifdef ADDSUB_SAT_EN
    // On overflow the true value carries the minuend's sign.
    if (ovf_c) begin
      r_fin = x[dw-1] ? {1'b1, {(dw-1){1'b0}}} : {1'b0, {(dw-1){1'b1}}};
    end
`else
    r_fin  = r_wrap;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (en1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op_q <= bus.op;
          s1_a_q  <= bus.dataa;
          s1_b_q  <= bus.datab;
        end
      end
      if (en2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q <= r_fin;
          carry_q  <= full[dw];
          ovf_q    <= ovf_c;
          zero_q   <= (r_fin == '0);
        end
      end
      if (mv2 && s1_op_q[1]) begin
        acc_q <= r_fin;
      end else if (bus.acc_clr) begin
        acc_q <= '0;
      end
    end
  end

  assign bus.in_ready  = en1;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Scoreboard bench for addsub_acc_pipe (dw=8): directed ops push expectations, a monitor pops them.
module tb_addsub_acc_pipe;

  logic clk;
  logic reset;

  addsub_acc_pipe_if #(.dw(8)) ifc ();

  addsub_acc_pipe #(.dw(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       o;
    logic       z;
    bit         chk_acc;
    logic [7:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   n_total;
  int   n_passed;

`ifdef ADDSUB_SAT_EN
  localparam logic [7:0] R7F01 = 8'h7F;
  localparam logic [7:0] R8001 = 8'h80;
  localparam logic [7:0] R8080 = 8'h80;
  localparam logic       Z8080 = 1'b0;
`else
  localparam logic [7:0] R7F01 = 8'h80;
  localparam logic [7:0] R8001 = 8'h7F;
  localparam logic [7:0] R8080 = 8'h00;
  localparam logic       Z8080 = 1'b1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor: every accepted output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got result %0h required no output", ifc.result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(ifc.result), 32'(e.r));
        chk("carry", 32'(ifc.carry), 32'(e.c));
        chk("ovf", 32'(ifc.ovf), 32'(e.o));
        chk("zero", 32'(ifc.zero), 32'(e.z));
        if (e.chk_acc) chk("acc", 32'(ifc.acc), 32'(e.a));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input logic [7:0] er, input logic ec, input logic eo,
                       input logic ez, input bit ca, input logic [7:0] ea, input bit clr_after);
    bit   taken;
    exp_t e;
    taken        = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.op       = op;
    ifc.dataa    = a;
    ifc.datab    = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifc.in_ready === 1'b1) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) begin
      n_total++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles required 1");
      ifc.in_valid = 1'b0;
      return;
    end
    if (push) begin
      e = '{r: er, c: ec, o: eo, z: ez, chk_acc: ca, a: ea};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    if (clr_after) begin
      ifc.acc_clr = 1'b1;
      @(posedge clk);
      #1;
      ifc.acc_clr = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    n_total       = 0;
    n_passed      = 0;
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.op        = 2'b00;
    ifc.dataa     = '0;
    ifc.datab     = '0;
    ifc.acc_clr   = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_result", 32'(ifc.result), 32'd0);
    chk("rst_flags", 32'({ifc.carry, ifc.ovf, ifc.zero}), 32'd0);
    chk("rst_acc", 32'(ifc.acc), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Plain add/sub, flags and wrap-around (saturation-dependent values via localparams).
    issue(2'b01, 8'h05, 8'h03, 1, 8'h08, 0, 0, 0, 0, 8'h00, 0);
    issue(2'b00, 8'h03, 8'h05, 1, 8'hFE, 1, 0, 0, 0, 8'h00, 0);
    issue(2'b00, 8'h2A, 8'h2A, 1, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    issue(2'b01, 8'h7F, 8'h01, 1, R7F01, 0, 1, 0, 0, 8'h00, 0);
    issue(2'b01, 8'hFF, 8'hFF, 1, 8'hFE, 1, 0, 0, 0, 8'h00, 0);
    issue(2'b00, 8'h80, 8'h01, 1, R8001, 0, 1, 0, 0, 8'h00, 0);
    issue(2'b01, 8'h80, 8'h80, 1, R8080, 1, 1, Z8080, 0, 8'h00, 0);
    drain();

    // Accumulator: clear, three back-to-back adds, one subtract.
    ifc.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    ifc.acc_clr = 1'b0;
    @(negedge clk);
    chk("acc_after_clr", 32'(ifc.acc), 32'd0);
    @(posedge clk);
    #1;
    issue(2'b10, 8'h10, 8'h00, 1, 8'h10, 0, 0, 0, 1, 8'h10, 0);
    issue(2'b10, 8'h10, 8'h00, 1, 8'h20, 0, 0, 0, 1, 8'h20, 0);
    issue(2'b10, 8'h10, 8'h00, 1, 8'h30, 0, 0, 0, 1, 8'h30, 0);
    drain();
    chk("acc_after_3_adds", 32'(ifc.acc), 32'h30);
    issue(2'b11, 8'h40, 8'h00, 1, 8'hF0, 1, 0, 0, 1, 8'hF0, 0);
    drain();
    // acc_clr on the same edge the acc op enters S2: 0 + 7, not F0 + 7.
    issue(2'b10, 8'h07, 8'h00, 1, 8'h07, 0, 0, 0, 1, 8'h07, 1);
    drain();
    chk("acc_clear_then_op", 32'(ifc.acc), 32'h07);

    // Backpressure: three ops offered with the consumer stalled.
    ifc.out_ready = 1'b0;
    fork
      begin
        issue(2'b01, 8'h01, 8'h02, 1, 8'h03, 0, 0, 0, 0, 8'h00, 0);
        issue(2'b00, 8'h10, 8'h01, 1, 8'h0F, 0, 0, 0, 0, 8'h00, 0);
        issue(2'b01, 8'h20, 8'h20, 1, 8'h40, 0, 0, 0, 0, 8'h00, 0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_out_valid", 32'(ifc.out_valid), 32'd1);
        chk("stall_result", 32'(ifc.result), 32'h03);
        chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("stall_result_held", 32'(ifc.result), 32'h03);
        chk("stall_in_ready_held", 32'(ifc.in_ready), 32'd0);
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight: nothing from them may emerge.
    ifc.out_ready = 1'b0;
    issue(2'b10, 8'h55, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    issue(2'b01, 8'h11, 8'h11, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_acc", 32'(ifc.acc), 32'd0);
    chk("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
    ifc.out_ready = 1'b1;
    drain();
    issue(2'b01, 8'h01, 8'h01, 1, 8'h02, 0, 0, 0, 0, 8'h00, 0);
    issue(2'b10, 8'h09, 8'h00, 1, 8'h09, 0, 0, 0, 1, 8'h09, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    drain();
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d outstanding results required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
